// File: rtl/w5300_ready_gate.sv
// W5300 reset/settle tracker: gates QL accesses until the chip is out of reset and its PLL has settled.
// Optional ACCESS_TIMEOUT_EN adds a bounded-wait bus-error pulse on access_err.
module w5300_ready_gate #(
    parameter int SETTLE_CYCLES  = 75000,
    parameter int CNT_WIDTH      = 17,
    parameter int MIN_LOW_CYCLES = 15,
    parameter int TIMEOUT_CYCLES = 150000
) (
    input  logic       clk,
    input  logic       resetl,
    input  logic       w5300_resetl,
    input  logic       access_req,
    output logic       access_grant,
    output logic       access_wait,
    output logic       ready,
    output logic       short_reset,
    output logic [7:0] reset_events,
    output logic       access_err
);

    localparam int                   LOW_W       = $clog2(MIN_LOW_CYCLES + 1);
    localparam logic [LOW_W-1:0]     LOW_MAX     = LOW_W'(MIN_LOW_CYCLES);
    localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);

    if ((2 ** CNT_WIDTH) <= SETTLE_CYCLES || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("w5300_ready_gate: CNT_WIDTH too small for SETTLE_CYCLES, or TIMEOUT_CYCLES < 1");
    end

    typedef enum logic [1:0] {
        IN_RESET,
        SETTLING,
        READY
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   settle_cnt_q, settle_cnt_d;
    logic [LOW_W-1:0]       low_cnt_q, low_cnt_d;
    logic                   ready_q, ready_d;
    logic                   short_q, short_d;
    logic [7:0]             events_q, events_d;
    logic                   powerup_q, powerup_d;   // first exit after block reset is pending

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state_q      <= IN_RESET;
            settle_cnt_q <= '0;
            low_cnt_q    <= '0;
            ready_q      <= 1'b0;
            short_q      <= 1'b0;
            events_q     <= '0;
            powerup_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            low_cnt_q    <= low_cnt_d;
            ready_q      <= ready_d;
            short_q      <= short_d;
            events_q     <= events_d;
            powerup_q    <= powerup_d;
        end
    end

    // NOTE: every variable gets a hold default first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        low_cnt_d    = low_cnt_q;
        ready_d      = ready_q;
        short_d      = short_q;
        events_d     = events_q;
        powerup_d    = powerup_q;

        case (state_q)
            IN_RESET: begin
                if (!w5300_resetl) begin
                    if (low_cnt_q < LOW_MAX) low_cnt_d = low_cnt_q + 1'b1;
                end else begin
                    state_d      = SETTLING;
                    settle_cnt_d = '0;
                    powerup_d    = 1'b0;
                    if (events_q != 8'hFF) events_d = events_q + 8'd1;
                    if (!powerup_q && (low_cnt_q < LOW_MAX)) short_d = 1'b1;
                end
            end
            SETTLING: begin
                // A low sample beats a coincident settle completion.
                if (!w5300_resetl) begin
                    state_d      = IN_RESET;
                    low_cnt_d    = LOW_W'(1);
                    settle_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_d = READY;
                        ready_d = 1'b1;
                    end
                end
            end
            READY: begin
                if (!w5300_resetl) begin
                    state_d   = IN_RESET;
                    ready_d   = 1'b0;
                    low_cnt_d = LOW_W'(1);
                end
            end
            default: state_d = IN_RESET;
        endcase
    end

    // The raw line term blocks a grant in the cycle the line falls, before ready drops.
    assign access_grant = access_req & ready_q & w5300_resetl;
    assign access_wait  = access_req & ~access_grant;
    assign ready        = ready_q;
    assign short_reset  = short_q;
    assign reset_events = events_q;

`ifdef ACCESS_TIMEOUT_EN
    localparam int                WAIT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;

    // Counter parks at WAIT_MAX so the error fires once per continuous wait.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        err_d      = 1'b0;
        if (!access_wait) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
            err_d      = (wait_cnt_q == WAIT_MAX - 1'b1);
        end
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign access_err = err_q;
`else
    assign access_err = 1'b0;
`endif

endmodule

// File: tb/tb_w5300_ready_gate.sv
// Self-checking bench for w5300_ready_gate: directed lifecycle steps plus random
// reset patterns, compared every cycle against a run-length reference model.
module tb_w5300_ready_gate;

    localparam int S = 20;
    localparam int MIN = 8;
    localparam int T = 50;

    logic       clk = 1'b0;
    logic       resetl;
    logic       w5300_resetl;
    logic       access_req;
    logic       access_grant;
    logic       access_wait;
    logic       ready;
    logic       short_reset;
    logic [7:0] reset_events;
    logic       access_err;

    always #5 clk = ~clk;

    w5300_ready_gate #(
        .SETTLE_CYCLES (S),
        .CNT_WIDTH     (17),
        .MIN_LOW_CYCLES(MIN),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk          (clk),
        .resetl       (resetl),
        .w5300_resetl (w5300_resetl),
        .access_req   (access_req),
        .access_grant (access_grant),
        .access_wait  (access_wait),
        .ready        (ready),
        .short_reset  (short_reset),
        .reset_events (reset_events),
        .access_err   (access_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: run lengths of the sampled reset line.
    int m_low_run;
    int m_high_run;
    int m_events;
    bit m_short;
    bit m_in_low;
    bit m_powerup;
    int m_wait_run;
    bit m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        return m_high_run >= S + 1;
    endfunction

    task automatic model_reset();
        m_low_run  = 0;
        m_high_run = 0;
        m_events   = 0;
        m_short    = 1'b0;
        m_in_low   = 1'b1;
        m_powerup  = 1'b1;
        m_wait_run = 0;
        m_err      = 1'b0;
    endtask

    task automatic check_regs();
        check("ready", 32'(ready), 32'(m_ready()));
        check("short_reset", 32'(short_reset), 32'(m_short));
        check("reset_events", 32'(reset_events), 32'(m_events));
        check("access_err", 32'(access_err), 32'(m_err));
    endtask

    // One clock: drive at negedge, check combinational outputs, advance model on posedge.
    task automatic cycle(input bit wv, input bit rq);
        bit g;
        @(negedge clk);
        resetl       = 1'b1;
        w5300_resetl = wv;
        access_req   = rq;
        #1;
        g = rq & m_ready() & wv;
        check("access_grant", 32'(access_grant), 32'(g));
        check("access_wait", 32'(access_wait), 32'(rq & ~g));
        @(posedge clk);
        if (rq & ~g) m_wait_run++;
        else         m_wait_run = 0;
`ifdef ACCESS_TIMEOUT_EN
        m_err = (m_wait_run == T);
`else
        m_err = 1'b0;
`endif
        if (!wv) begin
            m_in_low = 1'b1;
            m_low_run++;
            m_high_run = 0;
        end else begin
            if (m_in_low) begin
                if (m_events < 255) m_events++;
                if (!m_powerup && m_low_run < MIN) m_short = 1'b1;
                m_powerup = 1'b0;
                m_in_low  = 1'b0;
                m_low_run = 0;
            end
            m_high_run++;
        end
        #1;
        check_regs();
    endtask

    task automatic run(input int n, input bit wv, input bit rq);
        for (int i = 0; i < n; i++) cycle(wv, rq);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        resetl       = 1'b0;
        w5300_resetl = 1'b1;
        access_req   = 1'b1;
        model_reset();
        #1;
        check_regs();
        repeat (n) @(posedge clk);
        #1;
        check_regs();
        check("reset_grant", 32'(access_grant), 32'd0);
        check("reset_wait", 32'(access_wait), 32'd1);
    endtask

    initial begin
        int first;
        int pulses;
        resetl       = 1'b0;
        w5300_resetl = 1'b1;
        access_req   = 1'b0;
        model_reset();

        // 1. Power-up: ready exactly 21 edges after release.
        do_reset(3);
        first = 0;
        for (int i = 1; i <= 25; i++) begin
            cycle(1'b1, 1'($urandom_range(0, 1)));
            if (ready === 1'b1 && first == 0) first = i;
        end
        check("powerup_ready_edge", 32'(first), 32'd21);
        check("powerup_events", 32'(reset_events), 32'd1);

        // 2. Normal 10-cycle reset from READY.
        cycle(1'b0, 1'b0);
        check("ready_drop_first_low", 32'(ready), 32'd0);
        run(9, 1'b0, 1'b0);
        first = 0;
        for (int i = 1; i <= 25; i++) begin
            cycle(1'b1, 1'b0);
            if (ready === 1'b1 && first == 0) first = i;
        end
        check("resettle_ready_edge", 32'(first), 32'd21);
        check("events_after_second", 32'(reset_events), 32'd2);

        // 3. Short-reset boundary: 8 low is legal, 7 and 3 are short; sticky until resetl.
        run(MIN, 1'b0, 1'b0);
        run(25, 1'b1, 1'b0);
        check("min_low_not_short", 32'(short_reset), 32'd0);
        run(MIN - 1, 1'b0, 1'b0);
        run(25, 1'b1, 1'b0);
        check("low7_short", 32'(short_reset), 32'd1);
        run(3, 1'b0, 1'b0);
        run(25, 1'b1, 1'b0);
        run(10, 1'b0, 1'b0);
        run(25, 1'b1, 1'b0);
        check("short_sticky", 32'(short_reset), 32'd1);
        do_reset(2);
        check("short_cleared", 32'(short_reset), 32'd0);
        run(25, 1'b1, 1'b0);

        // 4. access_req held across reset and settle; grant dies in the falling cycle.
        run(25, 1'b1, 1'b1);
        @(negedge clk);
        w5300_resetl = 1'b0;
        access_req   = 1'b1;
        #1;
        check("grant_on_fall", 32'(access_grant), 32'd0);
        check("wait_on_fall", 32'(access_wait), 32'd1);
        run(5, 1'b0, 1'b1);
        run(25, 1'b1, 1'b1);

        // 5. Reset at settle_cnt=15, then restart; then saturating event count.
        run(4, 1'b0, 1'b0);
        run(16, 1'b1, 1'b0);
        run(2, 1'b0, 1'b0);
        check("aborted_settle_not_ready", 32'(ready), 32'd0);
        run(25, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            cycle(1'b0, 1'b0);
            cycle(1'b1, 1'b0);
        end
        check("events_saturate", 32'(reset_events), 32'd255);

        // 6. Access held against a long reset: single timeout pulse when enabled.
        pulses = 0;
        for (int i = 0; i < 120; i++) begin
            cycle(1'b0, 1'b1);
            if (access_err === 1'b1) pulses++;
        end
`ifdef ACCESS_TIMEOUT_EN
        check("timeout_pulses", 32'(pulses), 32'd1);
`else
        check("timeout_pulses", 32'(pulses), 32'd0);
`endif
        run(25, 1'b1, 1'b0);

        // Randomised reset lengths and request patterns.
        for (int seg = 0; seg < 40; seg++) begin
            int lw;
            int hw;
            lw = $urandom_range(1, 12);
            hw = $urandom_range(1, 30);
            for (int i = 0; i < lw; i++) cycle(1'b0, 1'($urandom_range(0, 1)));
            for (int i = 0; i < hw; i++) cycle(1'b1, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
